// File: rtl/seq_subtractor_pkg.sv
// Shared types and helpers for the multi-cycle signed subtractor.
package seq_subtractor_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_CHUNK_WIDTH = 4;
    localparam int unsigned N               = DEF_DATA_WIDTH / DEF_CHUNK_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Signed overflow of a - b: operand signs differ and the result sign left the minuend's.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/seq_subtractor_sub_slice.sv
// One slice of a + b_n + cin, where b_n is the already-inverted subtrahend slice.
module sub_slice #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b_n,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;

    assign w_g = i_a & i_b_n;
    assign w_p = i_a ^ i_b_n;

    always_comb begin
        logic c;
        o_s = '0;
        c   = i_cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_s[i] = w_p[i] ^ c;
            c      = w_g[i] | (w_p[i] & c);
        end
        o_cout = c;
    end

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle signed subtractor: A - B as A + ~B + 1, one CHUNK_WIDTH slice per RUN cycle.
module seq_subtractor
    import seq_subtractor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int unsigned NUM_SLICES = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    state_t r_state;
    state_t w_next;

    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_nb;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_carry;
    logic                   r_ovf;
    logic [CNT_W-1:0]       r_cnt;

    logic [CHUNK_WIDTH-1:0] w_s;
    logic                   w_cout;
    logic                   w_start;
    logic                   w_last;

    assign w_start = in_valid & in_ready;
    assign w_last  = (r_state == RUN) && (r_cnt == LAST_SLICE);

    // Operands shift right so the active slice is always the low CHUNK_WIDTH bits.
    sub_slice #(
        .WIDTH(CHUNK_WIDTH)
    ) u_slice (
        .i_a   (r_a[CHUNK_WIDTH-1:0]),
        .i_b_n (r_nb[CHUNK_WIDTH-1:0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_cout(w_cout)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_nb     <= '0;
            r_result <= '0;
            r_carry  <= 1'b1;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_a     <= A;
            r_nb    <= ~B;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> CHUNK_WIDTH;
            r_nb    <= r_nb >> CHUNK_WIDTH;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            r_result[int'(r_cnt) * CHUNK_WIDTH +: CHUNK_WIDTH] <= w_s;
            // On the last slice the low bits hold the operand MSBs; ~B is re-inverted here.
            if (w_last) r_ovf <= sub_overflow(r_a[CHUNK_WIDTH-1], ~r_nb[CHUNK_WIDTH-1], w_s[CHUNK_WIDTH-1]);
        end
    end

    assign result   = r_result;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor at CHUNK_WIDTH 4, 16 and 1 (N = 4, 1, 16).
module tb_seq_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [3];
    logic        in_ready_s  [3];
    logic [15:0] a_s         [3];
    logic [15:0] b_s         [3];
    logic        out_valid_s [3];
    logic        out_ready_s [3];
    logic [15:0] res_s       [3];
    logic        ovf_s       [3];

    int n_chk  = 0;
    int n_fail = 0;
    int nslc [3] = '{4, 1, 16};

    seq_subtractor #(.DATA_WIDTH(16), .CHUNK_WIDTH(4)) u_dut_cw4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .A(a_s[0]), .B(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .result(res_s[0]), .overflow(ovf_s[0])
    );

    seq_subtractor #(.DATA_WIDTH(16), .CHUNK_WIDTH(16)) u_dut_cw16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .A(a_s[1]), .B(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .result(res_s[1]), .overflow(ovf_s[1])
    );

    seq_subtractor #(.DATA_WIDTH(16), .CHUNK_WIDTH(1)) u_dut_cw1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .A(a_s[2]), .B(b_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .result(res_s[2]), .overflow(ovf_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic start_and_wait(input int d, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] exp_r, input logic exp_ov);
        int lat;
        @(negedge clk);
        in_valid_s[d] = 1'b1;
        a_s[d] = a;
        b_s[d] = b;
        @(posedge clk);
        #1;
        in_valid_s[d] = 1'b0;
        a_s[d] = 16'($urandom);
        b_s[d] = 16'($urandom);
        chk("busy_in_ready", d, 32'(in_ready_s[d]), 32'd0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid_s[d]) begin
                lat = i - 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat == 0 && out_valid_s[d]) lat = 40;
        chk("latency", d, 32'(lat), 32'(nslc[d]));
        chk("result", d, 32'(res_s[d]), 32'(exp_r));
        chk("overflow", d, 32'(ovf_s[d]), 32'(exp_ov));
        chk("done_in_ready", d, 32'(in_ready_s[d]), 32'd0);
    endtask

    task automatic consume(input int d);
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[d] = 1'b0;
        chk("consume_out_valid", d, 32'(out_valid_s[d]), 32'd0);
        chk("consume_in_ready", d, 32'(in_ready_s[d]), 32'd1);
    endtask

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_r, input logic exp_ov);
        start_and_wait(d, a, b, exp_r, exp_ov);
        consume(d);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        ov;
    } vec_t;

    vec_t vecs [10] = '{
        '{16'h0005, 16'h0003, 16'h0002, 1'b0},
        '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1},
        '{16'h8000, 16'h0001, 16'h7FFF, 1'b1},
        '{16'h0000, 16'h8000, 16'h8000, 1'b1},
        '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0},
        '{16'h8000, 16'h8000, 16'h0000, 1'b0},
        '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1},
        '{16'h1234, 16'h0234, 16'h1000, 1'b0},
        '{16'h0001, 16'h0002, 16'hFFFF, 1'b0},
        '{16'h8000, 16'h7FFF, 16'h0001, 1'b1}
    };

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid_s[d]  = 1'b0;
            out_ready_s[d] = 1'b0;
            a_s[d] = '0;
            b_s[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_in_ready", d, 32'(in_ready_s[d]), 32'd1);
            chk("reset_out_valid", d, 32'(out_valid_s[d]), 32'd0);
            chk("reset_result", d, 32'(res_s[d]), 32'd0);
            chk("reset_overflow", d, 32'(ovf_s[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++)
            for (int v = 0; v < 10; v++)
                run_op(d, vecs[v].a, vecs[v].b, vecs[v].r, vecs[v].ov);

        // Backpressure: result held while out_ready low, in_valid pulses ignored.
        start_and_wait(0, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_s[0] = 1'b1;
            a_s[0] = 16'h1111;
            b_s[0] = 16'h2222;
            @(posedge clk);
            #1;
            in_valid_s[0] = 1'b0;
            chk("bp_result", 0, 32'(res_s[0]), 32'h0000FFFF);
            chk("bp_overflow", 0, 32'(ovf_s[0]), 32'd1);
            chk("bp_out_valid", 0, 32'(out_valid_s[0]), 32'd1);
            chk("bp_in_ready", 0, 32'(in_ready_s[0]), 32'd0);
        end
        consume(0);
        chk("hold_after_consume", 0, 32'(res_s[0]), 32'h0000FFFF);
        run_op(0, 16'h0010, 16'h0001, 16'h000F, 1'b0);

        // Asynchronous reset mid-RUN at slice 2.
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        a_s[0] = 16'h5555;
        b_s[0] = 16'h1111;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("midrun_out_valid", 0, 32'(out_valid_s[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 0, 32'(out_valid_s[0]), 32'd0);
        chk("rst_in_ready", 0, 32'(in_ready_s[0]), 32'd1);
        chk("rst_result", 0, 32'(res_s[0]), 32'd0);
        chk("rst_overflow", 0, 32'(ovf_s[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 16'h1234, 16'h0234, 16'h1000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
